// File: rtl/sequential_divider.sv
// rtl/sequential_divider.sv - multi-cycle signed restoring divider (quotient/LO, remainder/HI)
// One trial subtraction per cycle on operand magnitudes; sign fix-up and divide-by-zero in FIX.
module sequential_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q;
  logic [4:0]       count_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] bmag_q;
  logic [WIDTH-1:0] a_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic             b_zero_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             busy_q;
  logic             done_q;
  logic             div_by_zero_q;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             trial_ok;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;
  logic [WIDTH-1:0] quotient_d;
  logic [WIDTH-1:0] remainder_d;
  logic             div_by_zero_d;

  // The most negative value maps to itself, which read unsigned is exactly 2^(WIDTH-1).
  assign a_mag = A[WIDTH-1] ? (WIDTH'(0) - A) : A;
  assign b_mag = B[WIDTH-1] ? (WIDTH'(0) - B) : B;

  // rem_q < |B| <= 2^(WIDTH-1), so the shifted value fits WIDTH+1 bits and the
  // WIDTH+1-bit difference has a valid sign bit acting as the borrow.
  always_comb begin
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    diff     = shifted - {1'b0, bmag_q};
    trial_ok = ~diff[WIDTH];
    rem_d    = trial_ok ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_d    = {dvd_q[WIDTH-2:0], trial_ok};
  end

  always_comb begin
    quotient_d    = (sign_a_q ^ sign_b_q) ? (WIDTH'(0) - dvd_q) : dvd_q;
    remainder_d   = sign_a_q ? (WIDTH'(0) - rem_q) : rem_q;
    div_by_zero_d = 1'b0;
    if (b_zero_q) begin
      quotient_d    = '0;
      remainder_d   = a_q;
      div_by_zero_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      rem_q         <= '0;
      dvd_q         <= '0;
      bmag_q        <= '0;
      a_q           <= '0;
      sign_a_q      <= 1'b0;
      sign_b_q      <= 1'b0;
      b_zero_q      <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sign_a_q <= A[WIDTH-1];
            sign_b_q <= B[WIDTH-1];
            b_zero_q <= (B == '0);
            a_q      <= A;
            bmag_q   <= b_mag;
            dvd_q    <= a_mag;
            rem_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
          rem_q   <= rem_d;
          dvd_q   <= dvd_d;
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          quotient_q    <= quotient_d;
          remainder_q   <= remainder_d;
          div_by_zero_q <= div_by_zero_d;
          done_q        <= 1'b1;
          busy_q        <= 1'b0;
          state_q       <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = div_by_zero_q;

endmodule
